// File: rtl/uart_bus_master.sv
// uart_bus_master: turns framed UART bytes into single-word bus accesses and
// sends a short reply through a UART transmitter byte interface.
//   Frames: 'W' a0..a3 d0..d3 | 'R' a0..a3 | 'P'  (all fields little-endian)
//   Replies: 'K' (write ok / ping), 'D' + 4 data bytes (read ok), 'F' (fault),
//            '?' (unknown command).
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   rx_valid_in/data_in - received byte strobe and value
//   tx_valid_out/data_out/ready_in - reply byte handshake
//   address_out, read_out, write_out, write_mask_out, write_value_out - bus request
//   read_value_in, ready_in, fault_in - bus completion
//   busy_out            - high whenever a frame or transaction is in progress
module uart_bus_master #(
    parameter int unsigned TIMEOUT       = 1000000,
    parameter int unsigned TIMEOUT_WIDTH = $clog2(TIMEOUT + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_valid_in,
    input  logic [7:0]               rx_data_in,
    output logic                     tx_valid_out,
    output logic [7:0]               tx_data_out,
    input  logic                     tx_ready_in,
    output logic [31:0]              address_out,
    output logic                     read_out,
    output logic                     write_out,
    output logic [3:0]               write_mask_out,
    output logic [31:0]              write_value_out,
    input  logic [31:0]              read_value_in,
    input  logic                     ready_in,
    input  logic                     fault_in,
    output logic                     busy_out
);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_P = 8'h50;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_Q = 8'h3F;
    localparam logic [7:0] RSP_D = 8'h44;
    localparam logic [7:0] RSP_F = 8'h46;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        BUS  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic                     is_write_q, is_write_d;
    logic [1:0]               byte_cnt_q, byte_cnt_d;
    logic [TIMEOUT_WIDTH-1:0] timeout_q, timeout_d;
    logic [31:0]              addr_q, addr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [31:0]              rdata_q, rdata_d;
    logic [2:0]               resp_idx_q, resp_idx_d;
    logic [2:0]               resp_last_q, resp_last_d;
    logic                     tx_valid_q, tx_valid_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic                     rd_q, rd_d;
    logic                     wr_q, wr_d;
    logic [3:0]               mask_q, mask_d;
    logic [31:0]              addr_out_q, addr_out_d;
    logic [31:0]              wval_q, wval_d;
    logic                     busy_q, busy_d;

    logic timeout_hit_c;
    logic tx_done_c;
    logic rx_cmd_rw_c;

    assign timeout_hit_c = (timeout_q == TIMEOUT_WIDTH'(TIMEOUT));
    assign tx_done_c     = tx_valid_q && tx_ready_in;
    assign rx_cmd_rw_c   = (rx_data_in == CMD_W) || (rx_data_in == CMD_R);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an expired timeout takes priority over a same-cycle byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_valid_in) begin
                    state_d = rx_cmd_rw_c ? ADDR : RESP;
                end
            end
            ADDR: begin
                if (timeout_hit_c) begin
                    state_d = IDLE;
                end else if (rx_valid_in && (byte_cnt_q == 2'd3)) begin
                    state_d = is_write_q ? DATA : BUS;
                end
            end
            DATA: begin
                if (timeout_hit_c) begin
                    state_d = IDLE;
                end else if (rx_valid_in && (byte_cnt_q == 2'd3)) begin
                    state_d = BUS;
                end
            end
            BUS: begin
                if (ready_in) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (tx_done_c && (resp_idx_q == resp_last_q)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        is_write_d  = is_write_q;
        byte_cnt_d  = byte_cnt_q;
        timeout_d   = timeout_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        resp_idx_d  = resp_idx_q;
        resp_last_d = resp_last_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        mask_d      = mask_q;
        addr_out_d  = addr_out_q;
        wval_d      = wval_q;
        busy_d      = (state_d != IDLE);

        case (state_q)
            IDLE: begin
                byte_cnt_d = 2'd0;
                timeout_d  = '0;
                if (rx_valid_in) begin
                    is_write_d = (rx_data_in == CMD_W);
                    if (!rx_cmd_rw_c) begin
                        tx_valid_d  = 1'b1;
                        tx_data_d   = (rx_data_in == CMD_P) ? RSP_K : RSP_Q;
                        resp_idx_d  = 3'd0;
                        resp_last_d = 3'd0;
                    end
                end
            end
            ADDR, DATA: begin
                if (timeout_hit_c) begin
                    timeout_d  = '0;
                    byte_cnt_d = 2'd0;
                end else if (rx_valid_in) begin
                    timeout_d  = '0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (state_q == ADDR) begin
                        addr_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_in;
                    end else begin
                        wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data_in;
                    end
                end else begin
                    timeout_d = timeout_q + TIMEOUT_WIDTH'(1);
                end
            end
            BUS: begin
                if (ready_in) begin
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    mask_d      = 4'h0;
                    addr_out_d  = 32'h0;
                    wval_d      = 32'h0;
                    rdata_d     = read_value_in;
                    tx_valid_d  = 1'b1;
                    resp_idx_d  = 3'd0;
                    if (fault_in) begin
                        tx_data_d   = RSP_F;
                        resp_last_d = 3'd0;
                    end else if (is_write_q) begin
                        tx_data_d   = RSP_K;
                        resp_last_d = 3'd0;
                    end else begin
                        tx_data_d   = RSP_D;
                        resp_last_d = 3'd4;
                    end
                end
            end
            RESP: begin
                if (tx_done_c) begin
                    if (resp_idx_q == resp_last_q) begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                    end else begin
                        // Byte n (n>=1) of a read reply is read-data byte n-1
                        resp_idx_d = resp_idx_q + 3'd1;
                        tx_data_d  = rdata_q[{resp_idx_q[1:0], 3'b000} +: 8];
                    end
                end
            end
            default: ;
        endcase

        // Present the request the cycle after the final frame byte
        if ((state_d == BUS) && (state_q != BUS)) begin
            rd_d       = !is_write_q;
            wr_d       = is_write_q;
            mask_d     = is_write_q ? 4'hF : 4'h0;
            addr_out_d = {addr_d[31:2], 2'b00};
            wval_d     = is_write_q ? wdata_d : 32'h0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_write_q  <= 1'b0;
            byte_cnt_q  <= 2'd0;
            timeout_q   <= '0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            resp_idx_q  <= 3'd0;
            resp_last_q <= 3'd0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            mask_q      <= 4'h0;
            addr_out_q  <= 32'h0;
            wval_q      <= 32'h0;
            busy_q      <= 1'b0;
        end else begin
            is_write_q  <= is_write_d;
            byte_cnt_q  <= byte_cnt_d;
            timeout_q   <= timeout_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            resp_idx_q  <= resp_idx_d;
            resp_last_q <= resp_last_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            mask_q      <= mask_d;
            addr_out_q  <= addr_out_d;
            wval_q      <= wval_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_valid_out    = tx_valid_q;
    assign tx_data_out     = tx_data_q;
    assign address_out     = addr_out_q;
    assign read_out        = rd_q;
    assign write_out       = wr_q;
    assign write_mask_out  = mask_q;
    assign write_value_out = wval_q;
    assign busy_out        = busy_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with a short inter-byte timeout.
module tb_uart_bus_master;

    localparam int unsigned TO = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid_in;
    logic [7:0]  rx_data_in;
    logic        tx_valid_out;
    logic [7:0]  tx_data_out;
    logic        tx_ready_in;
    logic [31:0] address_out;
    logic        read_out;
    logic        write_out;
    logic [3:0]  write_mask_out;
    logic [31:0] write_value_out;
    logic [31:0] read_value_in;
    logic        ready_in;
    logic        fault_in;
    logic        busy_out;

    int checks = 0;
    int errors = 0;

    uart_bus_master #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_valid_in    (rx_valid_in),
        .rx_data_in     (rx_data_in),
        .tx_valid_out   (tx_valid_out),
        .tx_data_out    (tx_data_out),
        .tx_ready_in    (tx_ready_in),
        .address_out    (address_out),
        .read_out       (read_out),
        .write_out      (write_out),
        .write_mask_out (write_mask_out),
        .write_value_out(write_value_out),
        .read_value_in  (read_value_in),
        .ready_in       (ready_in),
        .fault_in       (fault_in),
        .busy_out       (busy_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid_in = 1'b1;
        rx_data_in  = b;
        tick();
        rx_valid_in = 1'b0;
        rx_data_in  = 8'h00;
    endtask

    // Wait (bounded) for a reply byte, check it, then accept it
    task automatic recv(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!tx_valid_out && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(tx_valid_out), 32'd1);
        check(tag, 32'(tx_data_out), 32'(exp));
        tx_ready_in = 1'b1;
        tick();
        tx_ready_in = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [7:0] hold_data;
        logic [7:0] wr_frame [9];
        wr_frame = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

        reset = 1'b0; rx_valid_in = 1'b0; rx_data_in = 8'h00; tx_ready_in = 1'b0;
        read_value_in = 32'h0; ready_in = 1'b0; fault_in = 1'b0;
        repeat (3) tick();
        check("rst_tx_valid", 32'(tx_valid_out), 32'd0);
        check("rst_bus", {26'd0, read_out, write_out, write_mask_out}, 32'd0);
        check("rst_addr", address_out, 32'h0);
        check("rst_wval", write_value_out, 32'h0);
        check("rst_busy", 32'(busy_out), 32'd0);
        reset = 1'b1;
        tick();

        // Write, with a stray byte during BUS that must be dropped
        foreach (wr_frame[i]) send_byte(wr_frame[i]);
        check("wr_write", 32'(write_out), 32'd1);
        check("wr_read", 32'(read_out), 32'd0);
        check("wr_addr", address_out, 32'h0000_0000);
        check("wr_value", write_value_out, 32'hDEAD_BEEF);
        check("wr_mask", 32'(write_mask_out), 32'hF);
        check("wr_busy", 32'(busy_out), 32'd1);
        send_byte(8'h50);
        check("wr_still", 32'(write_out), 32'd1);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check("wr_drop", {27'd0, write_out, write_mask_out}, 32'd0);
        recv("wr_K", 8'h4B);
        check("wr_done_valid", 32'(tx_valid_out), 32'd0);
        check("wr_idle", 32'(busy_out), 32'd0);

        // Read with three wait cycles
        send_byte(8'h52); send_byte(8'h04); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        cyc = 0;
        repeat (3) begin
            if (read_out && !write_out && address_out == 32'h0001_0004) cyc++;
            tick();
        end
        read_value_in = 32'h0000_00A5;
        ready_in = 1'b1;
        if (read_out && address_out == 32'h0001_0004) cyc++;
        tick();
        ready_in = 1'b0;
        read_value_in = 32'h0;
        check("rd_hold", 32'(cyc), 32'd4);
        check("rd_drop", 32'(read_out), 32'd0);
        recv("rd_D", 8'h44);
        recv("rd_b0", 8'hA5);
        recv("rd_b1", 8'h00);
        recv("rd_b2", 8'h00);
        recv("rd_b3", 8'h00);
        check("rd_idle", 32'(busy_out), 32'd0);

        // Fault; low address bits must be ignored
        send_byte(8'h52); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80);
        check("flt_addr", address_out, 32'h8000_0000);
        ready_in = 1'b1; fault_in = 1'b1; read_value_in = 32'h1234_5678;
        tick();
        ready_in = 1'b0; fault_in = 1'b0; read_value_in = 32'h0;
        recv("flt_F", 8'h46);
        check("flt_only", 32'(tx_valid_out), 32'd0);
        check("flt_idle", 32'(busy_out), 32'd0);

        // Ping and unknown command
        send_byte(8'h50);
        check("ping_nobus", {30'd0, read_out, write_out}, 32'd0);
        recv("ping_K", 8'h4B);
        send_byte(8'h13);
        check("unk_nobus", {30'd0, read_out, write_out}, 32'd0);
        recv("unk_Q", 8'h3F);

        // Backpressure on a read reply
        send_byte(8'h52); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        read_value_in = 32'h1122_3344; ready_in = 1'b1;
        tick();
        ready_in = 1'b0; read_value_in = 32'h0;
        hold_data = tx_data_out;
        cyc = 0;
        repeat (10) begin
            if (tx_valid_out && tx_data_out == 8'h44) cyc++;
            tick();
        end
        check("bp_first", 32'(hold_data), 32'h44);
        check("bp_stable", 32'(cyc), 32'd10);
        recv("bp_D", 8'h44);
        recv("bp_b0", 8'h44);
        recv("bp_b1", 8'h33);
        recv("bp_b2", 8'h22);
        recv("bp_b3", 8'h11);

        // Inter-byte timeout on a partial write frame
        send_byte(8'h57); send_byte(8'h01);
        cyc = 0;
        repeat (TO - 1) begin
            if (read_out || write_out || tx_valid_out) cyc++;
            tick();
        end
        check("to_busy_before", 32'(busy_out), 32'd1);
        repeat (3) begin
            if (read_out || write_out || tx_valid_out) cyc++;
            tick();
        end
        check("to_idle", 32'(busy_out), 32'd0);
        check("to_no_activity", 32'(cyc), 32'd0);
        send_byte(8'h50);
        recv("to_ping_K", 8'h4B);

        // Asynchronous reset during a pending read
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("ar_read_before", 32'(read_out), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("ar_read", 32'(read_out), 32'd0);
        check("ar_busy", 32'(busy_out), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        send_byte(8'h50);
        recv("ar_ping_K", 8'h4B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Debug/loader bus initiator that turns a byte stream from a UART receiver into single-word transactions on the common memory bus.
- Initiator-side counterpart of the address decoder and peripheral responders: ram, leds, uart, timer, flash.
- Lets a host peek and poke RAM and MMIO, or preload RAM before the CPU is released.
- Sits beside the bus arbiter as a second master. Replies go out through a UART transmitter byte interface.

Parameters:
TIMEOUT, 1000000, idle clock cycles allowed between bytes of one frame before the partial frame is discarded
TIMEOUT_WIDTH, $clog2(TIMEOUT+1), width of the inter-byte timeout counter

Ports:
clk  input  1  system clock; single clock domain
reset  input  1  asynchronous, active-low reset
rx_valid_in  input  1  one-cycle strobe: rx_data_in holds a received byte
rx_data_in  input  8  received byte
tx_valid_out  output  1  response byte valid
tx_data_out  output  8  response byte
tx_ready_in  input  1  transmitter accepts tx_data_out this cycle
address_out  output  32  bus address, word aligned (bits [1:0] forced to 0)
read_out  output  1  bus read request
write_out  output  1  bus write request
write_mask_out  output  4  byte enables; 4'b1111 during write, else 0
write_value_out  output  32  write data
read_value_in  input  32  read data, valid when ready_in=1
ready_in  input  1  transaction complete (also asserted on fault)
fault_in  input  1  address decode fault; sampled only when ready_in=1
busy_out  output  1  high in every state except IDLE

Behaviour:
Frame format:
- Command byte, then address as 4 bytes little-endian.
- 'W' (0x57) is followed by 4 data bytes, little-endian.
- 'R' (0x52) has no data bytes.
- 'P' (0x50) is a ping and carries no address.

Reset values (reset=0, asynchronous): state=IDLE. All outputs 0: tx_valid_out, tx_data_out, address_out, read_out, write_out, write_mask_out, write_value_out, busy_out. Byte counters and timeout counter = 0.

States:
- IDLE:
  - On rx_valid_in: 'W' or 'R' -> ADDR with byte count 0.
  - 'P' -> RESP with 'K' (0x4B).
  - Any other byte -> RESP with '?' (0x3F).
- ADDR: each rx byte fills address bits [8k+7:8k] for k = 0..3.
  - After byte 3: 'W' -> DATA; 'R' -> BUS.
- DATA: each rx byte fills write_value bits [8k+7:8k]. After byte 3 -> BUS.
- BUS:
  - read_out or write_out, address_out, write_mask_out and write_value_out are all asserted the cycle after the last frame byte is received.
  - They are held stable until the cycle ready_in=1, and deasserted the following cycle.
  - No timeout in BUS; the decoder guarantees a ready on every access.
- RESP: response queued by byte index. Byte n is held on tx_data_out with tx_valid_out=1 until a cycle with tx_ready_in=1; byte n+1 appears the next cycle.
  - Write ok: 'K'.
  - Read ok: 'D' (0x44) followed by read data as 4 bytes little-endian (5 bytes total).
  - Fault on either command: 'F' (0x46) only.
  - After the last byte is accepted -> IDLE.

Response capture:
- read_value_in and fault_in are captured in the ready_in cycle.
- tx_valid_out rises the next cycle.

Address alignment: address_out[1:0] is always 0; the received low bits are ignored.

Inter-byte timeout:
- In ADDR or DATA, the counter increments each cycle without rx_valid_in and clears on rx_valid_in.
- When it reaches TIMEOUT: return to IDLE, clear the counter, no response sent, no bus access.

Dropped input:
- rx_valid_in during BUS or RESP is dropped silently; there is no buffering.
- An rx byte in the same cycle as the timeout expiry is dropped.

Reset mid-operation: bus request and tx_valid_out drop immediately (asynchronously); a partially sent response is abandoned.

Test Plan:
- Write: 57 00 00 00 00 EF BE AD DE -> one write, address 0x00000000, value 0xDEADBEEF, mask 1111, held for 1 cycle with ready_in=1 -> tx 'K'.
- Read: 52 04 00 01 00 with responder returning 0x000000A5 after 3 wait cycles -> address_out=0x00010004 held 4 cycles -> tx 44 A5 00 00 00.
- Fault: 52 00 00 00 80 with ready_in=1, fault_in=1 -> tx 'F' only, then IDLE.
- Ping and unknown: 50 -> 'K'. 13 -> '?'. No bus activity for either.
- Backpressure and timeout: hold tx_ready_in=0 for 10 cycles -> tx_data_out stable, no byte lost. Send 57 01, then idle TIMEOUT cycles -> IDLE, no bus access, next 'P' answered 'K'.
- Async reset while in BUS with read_out=1 -> read_out=0 and busy_out=0 without a clock edge; after release 'P' -> 'K'.
